fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/retire_counter.sv | 26 ++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its bench.
package fetch_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2,
        ST_TRAP   = 2'd3
    } state_e;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;
    localparam logic [6:0]        OPC_JAL   = 7'b1101111;

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter with synchronous clear; wraps at 2^WIDTH.
module retire_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/commit sequencer: owns the PC, fetches over req/ready, pulses exec_en once per instruction.
// Optional retired-instruction counter enabled by defining RETIRE_COUNT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            exec_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic            halted,
    output logic            trap,
    output logic [XLEN-1:0] instret
);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_imem_req;
    logic            r_exec_en;
    logic            r_halted;
    logic            r_trap;

    state_e          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic            w_req_nxt;
    logic            w_exec_nxt;
    logic            w_halted_nxt;
    logic            w_trap_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_misaligned;

    assign w_pc_inc     = r_pc + PC_STEP;
    assign w_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_imem_req <= 1'b0;
            r_exec_en  <= 1'b0;
            r_halted   <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_imem_req <= w_req_nxt;
            r_exec_en  <= w_exec_nxt;
            r_halted   <= w_halted_nxt;
            r_trap     <= w_trap_nxt;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they leave flops
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_req_nxt    = r_imem_req;
        w_exec_nxt   = 1'b0;
        w_halted_nxt = r_halted;
        w_trap_nxt   = r_trap;
        case (r_state)
            ST_FETCH: begin
                w_req_nxt = 1'b1;
                if (r_imem_req && imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_req_nxt   = 1'b0;
                    w_exec_nxt  = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_misaligned) begin
                    w_trap_nxt   = 1'b1;
                    w_halted_nxt = 1'b1;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = ST_TRAP;
                end else begin
                    w_pc_nxt = redirect_valid ? redirect_target : w_pc_inc;
                    if (halt_req) begin
                        w_halted_nxt = 1'b1;
                        w_req_nxt    = 1'b0;
                        w_state_nxt  = ST_HALTED;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                w_halted_nxt = 1'b1;
                w_req_nxt    = 1'b0;
                if (!halt_req) begin
                    w_halted_nxt = 1'b0;
                    w_req_nxt    = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_TRAP: begin
                w_trap_nxt   = 1'b1;
                w_halted_nxt = 1'b1;
                w_req_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign pc        = r_pc;
    assign pc_next   = w_pc_inc;
    assign exec_en   = r_exec_en;
    assign halted    = r_halted;
    assign trap      = r_trap;

`ifdef RETIRE_COUNT_EN
    // A committing instruction retires unless its redirect traps
    logic w_retire;
    assign w_retire = r_exec_en && !w_misaligned;

    retire_counter #(
        .WIDTH(XLEN)
    ) u_retire_counter (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_retire),
        .i_clr  (1'b0),
        .o_count(instret)
    );
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: architectural PC model plus directed scenarios.
module tb_fetch_sequencer;
    import fetch_pkg::*;

`ifdef RETIRE_COUNT_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instr, pc, pc_next, instret;
    logic        exec_en, halted, trap;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        halt_req = 1'b0;

    // Second DUT (RESET_PC at top of address space)
    logic        rst2 = 1'b1;
    logic        req2;
    logic [31:0] addr2;
    logic        ready2 = 1'b0;
    logic [31:0] rdata2;
    logic [31:0] instr2, pc2, pc_next2, instret2;
    logic        exec2, halted2, trap2;
    logic        redir2 = 1'b0;
    logic [31:0] target2 = 32'h0;
    logic        halt2 = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[26:2], OPC_JAL};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);

    fetch_sequencer u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .pc_next(pc_next), .exec_en(exec_en),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .halted(halted), .trap(trap), .instret(instret)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk(clk), .rst(rst2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ready(ready2), .imem_rdata(rdata2),
        .instr(instr2), .pc(pc2), .pc_next(pc_next2), .exec_en(exec2),
        .redirect_valid(redir2), .redirect_target(target2),
        .halt_req(halt2), .halted(halted2), .trap(trap2), .instret(instret2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec_at(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (exec_en && pc == a) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL wait_exec timeout waiting for pc=%h", a);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Architectural model: expected PC, trap status and retire count
    logic [31:0] exp_pc      = 32'h0;
    logic [31:0] exp_instret = 32'h0;
    bit          trapped     = 1'b0;
    bit          prev_exec   = 1'b0;
    logic [31:0] commit_pc[$];
    int          commit_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_pc      = 32'h0;
            exp_instret = 32'h0;
            trapped     = 1'b0;
            prev_exec   = 1'b0;
        end else begin
            chk("m_pc", pc, exp_pc);
            chk("m_pc_next", pc_next, exp_pc + 32'd4);
            chk("m_instret", instret, exp_instret);
            chk("m_trap", 32'(trap), 32'(trapped));
            if (trapped) begin
                chk("m_trap_req", 32'(imem_req), 32'd0);
                chk("m_trap_exec", 32'(exec_en), 32'd0);
                chk("m_trap_halted", 32'(halted), 32'd1);
            end
            if (imem_req) chk("m_addr", imem_addr, exp_pc);
            if (exec_en) begin
                chk("m_instr", instr, mem_word(exp_pc));
                chk("m_exec_no_req", 32'(imem_req), 32'd0);
                chk("m_exec_gap", 32'(prev_exec), 32'd0);
                commit_pc.push_back(pc);
                commit_cyc.push_back(cyc);
                if (redirect_valid && redirect_target[1:0] != 2'b00) begin
                    trapped = 1'b1;
                end else begin
                    exp_pc = redirect_valid ? redirect_target : exp_pc + 32'd4;
                    if (RC_EN) exp_instret = exp_instret + 32'd1;
                end
            end
            prev_exec = exec_en;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_exec", 32'(exec_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_instret", instret, 32'h0);

        rst = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk("req_rise", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential fetch, then halt requested while 0x8 is being fetched
        wait_exec_at(32'h4);
        tick();
        chk("fetch8_addr", imem_addr, 32'h8);
        halt_req = 1'b1;
        tick();
        chk("exec8_en", 32'(exec_en), 32'd1);
        chk("exec8_pc", pc, 32'h8);
        tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(imem_req), 32'd0);
        repeat (3) tick();
        chk("halt_held", 32'(halted), 32'd1);
        chk("halt_held_req", 32'(imem_req), 32'd0);
        chk("instret_3", instret, RC_EN ? 32'd3 : 32'd0);
        halt_req = 1'b0;
        tick();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'hC);
        chk("log_0", commit_pc[0], 32'h0);
        chk("log_1", commit_pc[1], 32'h4);
        chk("log_2", commit_pc[2], 32'h8);
        chk("issue_rate", 32'(commit_cyc[1] - commit_cyc[0]), 32'd2);

        // Stall at 0x10 with a stray redirect that must be ignored
        wait_exec_at(32'hC);
        imem_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            redirect_valid  = 1'b1;
            redirect_target = 32'h200;
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, 32'h10);
            chk("stall_exec", 32'(exec_en), 32'd0);
            tick();
        end
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        tick();
        chk("stall_commit", 32'(exec_en), 32'd1);
        chk("stall_pc", pc, 32'h10);
        tick();
        chk("stall_once", 32'(exec_en), 32'd0);

        // Jump at 0x20
        wait_exec_at(32'h20);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        chk("jump_pc_next", pc_next, 32'h24);
        tick();
        redirect_valid = 1'b0;
        chk("jump_addr", imem_addr, 32'h100);
        chk("jump_req", 32'(imem_req), 32'd1);

        // Misaligned jump at 0x108 traps
        wait_exec_at(32'h108);
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("trap_set", 32'(trap), 32'd1);
        chk("trap_halted", 32'(halted), 32'd1);
        chk("trap_pc", pc, 32'h108);
        chk("trap_req", 32'(imem_req), 32'd0);
        repeat (4) tick();
        chk("trap_sticky", 32'(trap), 32'd1);
        rst = 1'b1;
        #1;
        chk("trap_rst", 32'(trap), 32'd0);
        chk("trap_rst_halted", 32'(halted), 32'd0);
        tick();
        rst = 1'b0;

        // Reset during EXEC kills the commit strobe at once
        wait_exec_at(32'h0);
        rst = 1'b1;
        #1;
        chk("rst_exec_drop", 32'(exec_en), 32'd0);
        tick();
        rst = 1'b0;

        // PC wrap on the second instance
        rst2   = 1'b0;
        ready2 = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (exec2) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL wrap_exec timeout");
            end
        end
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next2, 32'h0);
        tick();
        chk("wrap_addr", addr2, 32'h0);
        chk("wrap_req", 32'(req2), 32'd1);
        chk("wrap_trap", 32'(trap2), 32'd0);
        ready2 = 1'b0;
        tick();
        chk("midfetch_req", 32'(req2), 32'd1);
        rst2 = 1'b1;
        #1;
        chk("midfetch_rst_req", 32'(req2), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
